out_display: RTL and testbench

- Downstream consumer of the CPU system's output port (`out_strobe`/`out_value`) on the DE0-Nano build. Equivalent of the breadboard computer's output register plus decimal display.
- Captures each strobed 8-bit value and converts it to BCD with a sequential double-dabble engine, unsigned or two's-complement.
- Drives a 4-digit multiplexed 7-segment display with leading-zero blanking.

---
 rtl/out_display.sv | 191 +++++++++++++++++++
 tb/tb_out_display.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_display.sv
// Output-port display: captures strobed bytes, converts them to BCD with a
// sequential double-dabble engine and scans a 4-digit multiplexed 7-segment display.
module out_display #(
  parameter int unsigned REFRESH_DIV    = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic       clk_en_i,
  input  logic       out_strobe_i,
  input  logic [7:0] out_value_i,
  input  logic       signed_i,
  output logic [6:0] seg_o,
  output logic [3:0] dig_o,
  output logic       busy_o,
  output logic [7:0] shown_o
);

  localparam int unsigned CW        = $clog2(REFRESH_DIV);
  localparam logic [6:0]  SEG_BLANK = 7'b0000000;
  localparam logic [6:0]  SEG_MINUS = 7'b1000000;
  localparam logic [6:0]  SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0]  DIG_OFF   = SEG_ACTIVE_LOW ? 4'hF : 4'h0;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    case (d)
      4'd0:    seg_pat = 7'b0111111;
      4'd1:    seg_pat = 7'b0000110;
      4'd2:    seg_pat = 7'b1011011;
      4'd3:    seg_pat = 7'b1001111;
      4'd4:    seg_pat = 7'b1100110;
      4'd5:    seg_pat = 7'b1101101;
      4'd6:    seg_pat = 7'b1111101;
      4'd7:    seg_pat = 7'b0000111;
      4'd8:    seg_pat = 7'b1111111;
      4'd9:    seg_pat = 7'b1101111;
      default: seg_pat = SEG_BLANK;
    endcase
  endfunction

  function automatic logic [19:0] dabble_step(input logic [19:0] r);
    logic [19:0] t;
    t = r;
    for (int unsigned i = 0; i < 3; i++) begin
      if (t[8 + 4*i +: 4] >= 4'd5)
        t[8 + 4*i +: 4] = t[8 + 4*i +: 4] + 4'd3;
    end
    dabble_step = {t[18:0], 1'b0};
  endfunction

  state_t          state_q, state_d;
  logic [19:0]     sh_q, sh_d;
  logic [2:0]      iter_q, iter_d;
  logic            neg_q, neg_d;
  logic [7:0]      cur_q, cur_d;
  logic            pend_q, pend_d;
  logic [7:0]      pend_val_q, pend_val_d;
  logic            pend_sgn_q, pend_sgn_d;
  logic [3:0][6:0] digit_q, digit_d, comp;
  logic [7:0]      shown_d;
  logic            busy_d;
  logic            accept, load_en, load_sgn;
  logic [7:0]      load_val, load_mag;
  logic [3:0]      bcd_h, bcd_t, bcd_o;
  logic [CW-1:0]   ref_cnt;
  logic [1:0]      scan_q;

  assign accept = out_strobe_i & clk_en_i;
  assign bcd_h  = sh_q[19:16];
  assign bcd_t  = sh_q[15:12];
  assign bcd_o  = sh_q[11:8];

  // Minus sign sits immediately left of the most significant shown digit.
  always_comb begin
    comp[0] = seg_pat(bcd_o);
    comp[1] = (bcd_h != 4'd0 || bcd_t != 4'd0) ? seg_pat(bcd_t) : SEG_BLANK;
    comp[2] = (bcd_h != 4'd0) ? seg_pat(bcd_h) : SEG_BLANK;
    comp[3] = SEG_BLANK;
    if (neg_q) begin
      if (bcd_h != 4'd0)      comp[3] = SEG_MINUS;
      else if (bcd_t != 4'd0) comp[2] = SEG_MINUS;
      else                    comp[1] = SEG_MINUS;
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      iter_q     <= '0;
      neg_q      <= 1'b0;
      cur_q      <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      pend_sgn_q <= 1'b0;
      digit_q    <= '0;
      shown_o    <= '0;
      busy_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      iter_q     <= iter_d;
      neg_q      <= neg_d;
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      pend_sgn_q <= pend_sgn_d;
      digit_q    <= digit_d;
      shown_o    <= shown_d;
      busy_o     <= busy_d;
    end
  end

  // A pending value is reloaded from IDLE on the edge after COMMIT, which
  // keeps every conversion (back-to-back or not) at a 10-cycle cadence.
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    iter_d     = iter_q;
    neg_d      = neg_q;
    cur_d      = cur_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    pend_sgn_d = pend_sgn_q;
    digit_d    = digit_q;
    shown_d    = shown_o;
    busy_d     = busy_o;
    load_en    = 1'b0;
    load_val   = out_value_i;
    load_sgn   = signed_i;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          load_en  = 1'b1;
          load_val = pend_val_q;
          load_sgn = pend_sgn_q;
          pend_d   = 1'b0;
        end else if (accept) begin
          load_en = 1'b1;
        end
      end
      CONV: begin
        sh_d   = dabble_step(sh_q);
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) state_d = COMMIT;
      end
      COMMIT: begin
        digit_d = comp;
        shown_d = cur_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept && (state_q != IDLE || pend_q)) begin
      pend_d     = 1'b1;
      pend_val_d = out_value_i;
      pend_sgn_d = signed_i;
    end
    load_mag = (load_sgn && load_val[7]) ? (~load_val + 8'd1) : load_val;
    if (load_en) begin
      sh_d    = {12'd0, load_mag};
      neg_d   = load_sgn & load_val[7];
      cur_d   = load_val;
      iter_d  = '0;
      state_d = CONV;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      ref_cnt <= '0;
      scan_q  <= '0;
      seg_o   <= SEG_OFF;
      dig_o   <= DIG_OFF;
    end else begin
      if (ref_cnt == CW'(REFRESH_DIV - 1)) begin
        ref_cnt <= '0;
        scan_q  <= scan_q + 2'd1;
      end else begin
        ref_cnt <= ref_cnt + CW'(1);
      end
      dig_o <= SEG_ACTIVE_LOW ? ~(4'b0001 << scan_q) : (4'b0001 << scan_q);
      seg_o <= SEG_ACTIVE_LOW ? ~digit_d[scan_q] : digit_d[scan_q];
    end
  end

endmodule

// File: tb/tb_out_display.sv
// Bench for out_display: arithmetic display model checked every cycle plus
// directed vectors with hand-computed segment/digit/latency expectations.
module tb_out_display;

  localparam int unsigned DIV = 4;

  logic       clk = 1'b0, rst = 1'b0, en = 1'b0, stb = 1'b0, sgn = 1'b0;
  logic [7:0] val = '0;
  logic [6:0] seg;
  logic [3:0] dig;
  logic       busy;
  logic [7:0] shown;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  out_display #(.REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk          (clk),
    .reset_i      (rst),
    .clk_en_i     (en),
    .out_strobe_i (stb),
    .out_value_i  (val),
    .signed_i     (sgn),
    .seg_o        (seg),
    .dig_o        (dig),
    .busy_o       (busy),
    .shown_o      (shown)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  // Model: conversion is a 9-edge countdown from load to commit.
  int         m_t = 0, m_k = 0;
  bit         m_pend = 0, m_ps = 0, m_cs = 0, m_busy = 0, m_acc = 0;
  logic [7:0] m_pv = '0, m_cv = '0, m_shown = '0;
  logic [6:0] m_disp [4] = '{7'h00, 7'h00, 7'h00, 7'h00};

  task automatic model_start(input logic [7:0] v, input bit s);
    m_cv   = v;
    m_cs   = s;
    m_t    = 9;
    m_busy = 1;
  endtask

  task automatic model_commit();
    int mag, h, tn, o;
    bit neg;
    neg = m_cs && m_cv[7];
    mag = neg ? 256 - int'(m_cv) : int'(m_cv);
    h   = mag / 100;
    tn  = (mag / 10) % 10;
    o   = mag % 10;
    m_disp[0] = pat(o);
    m_disp[1] = (mag >= 10)  ? pat(tn) : 7'h00;
    m_disp[2] = (mag >= 100) ? pat(h)  : 7'h00;
    m_disp[3] = 7'h00;
    if (neg) begin
      if (mag >= 100)     m_disp[3] = 7'b1000000;
      else if (mag >= 10) m_disp[2] = 7'b1000000;
      else                m_disp[1] = 7'b1000000;
    end
    m_shown = m_cv;
    m_busy  = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t = 0; m_pend = 0; m_busy = 0; m_shown = '0; m_k = 0;
      foreach (m_disp[i]) m_disp[i] = 7'h00;
    end else begin
      m_acc = stb && en;
      m_k++;
      if (m_t > 0) begin
        m_t--;
        if (m_t == 0) model_commit();
        if (m_acc) begin m_pend = 1; m_pv = val; m_ps = sgn; end
      end else if (m_pend) begin
        model_start(m_pv, m_ps);
        m_pend = 0;
        if (m_acc) begin m_pend = 1; m_pv = val; m_ps = sgn; end
      end else if (m_acc) begin
        model_start(val, sgn);
      end
    end
  end

  always @(negedge clk) begin
    int         idx;
    logic [3:0] ed;
    logic [6:0] es;
    if (m_k == 0) begin
      ed = 4'hF;
      es = 7'h7F;
    end else begin
      idx = ((m_k - 1) / DIV) % 4;
      ed  = ~(4'b0001 << idx);
      es  = ~m_disp[idx];
    end
    check("dig", dig, ed);
    check("seg", seg, es);
    check("busy", busy, m_busy);
    check("shown", shown, m_shown);
  end

  logic seen34 = 1'b0;
  always @(negedge clk) if (shown == 8'd34) seen34 = 1'b1;

  logic [3:0] scan_exp [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse(input logic [7:0] v, input logic s);
    stb = 1'b1; val = v; sgn = s;
    step();
    stb = 1'b0;
  endtask

  task automatic wait_dig(input logic [3:0] target, input logic [6:0] exp_seg, input string name);
    int n = 0;
    while (dig !== target && n < 20) begin
      step();
      n++;
    end
    if (dig !== target) check({name, "_timeout"}, dig, target);
    else                check(name, seg, exp_seg);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", n_errors);
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1; en = 1'b1;
    repeat (2) step();
    check("rst_seg", seg, 7'h7F);
    check("rst_dig", dig, 4'hF);
    check("rst_busy", busy, 0);
    check("rst_shown", shown, 0);
    rst = 1'b0;

    for (int j = 1; j <= 16; j++) begin
      step();
      check("scan_dig", dig, scan_exp[(j - 1) / 4]);
      check("scan_seg", seg, 7'h7F);
    end

    pulse(8'd255, 1'b0);
    check("busy_e0", busy, 1);
    repeat (8) step();
    check("busy_e8", busy, 1);
    check("shown_e8", shown, 0);
    step();
    check("busy_e9", busy, 0);
    check("shown_e9", shown, 255);
    wait_dig(4'b1110, 7'b0010010, "u255_d0");
    wait_dig(4'b1101, 7'b0010010, "u255_d1");
    wait_dig(4'b1011, 7'b0100100, "u255_d2");
    wait_dig(4'b0111, 7'h7F,      "u255_d3");

    pulse(8'hFF, 1'b1);
    repeat (9) step();
    check("shown_m1", shown, 8'hFF);
    wait_dig(4'b1110, 7'b1111001, "m1_d0");
    wait_dig(4'b1101, 7'b0111111, "m1_d1");
    wait_dig(4'b1011, 7'h7F,      "m1_d2");
    wait_dig(4'b0111, 7'h7F,      "m1_d3");

    pulse(8'h80, 1'b1);
    repeat (9) step();
    wait_dig(4'b1110, 7'b0000000, "m128_d0");
    wait_dig(4'b1101, 7'b0100100, "m128_d1");
    wait_dig(4'b1011, 7'b1111001, "m128_d2");
    wait_dig(4'b0111, 7'b0111111, "m128_d3");

    pulse(8'h00, 1'b0);
    repeat (9) step();
    wait_dig(4'b1110, 7'b1000000, "z_d0");
    wait_dig(4'b1101, 7'h7F,      "z_d1");

    pulse(8'd12, 1'b0);
    repeat (2) step();
    stb = 1'b1; val = 8'd34; step(); stb = 1'b0;
    step();
    stb = 1'b1; val = 8'd56; step(); stb = 1'b0;
    repeat (4) step();
    check("pend_shown_e9", shown, 12);
    check("pend_busy_e9", busy, 0);
    step();
    check("pend_busy_e10", busy, 1);
    repeat (8) step();
    check("pend_shown_e18", shown, 12);
    step();
    check("pend_shown_e19", shown, 56);
    check("never_34", seen34, 0);

    en = 1'b0; stb = 1'b1; val = 8'd99;
    step();
    stb = 1'b0; en = 1'b1;
    check("gated_busy", busy, 0);
    repeat (3) step();
    check("gated_busy_late", busy, 0);
    check("gated_shown", shown, 56);

    pulse(8'd7, 1'b0);
    repeat (8) step();
    stb = 1'b1; val = 8'd9; step(); stb = 1'b0;
    check("cedge_shown_e9", shown, 7);
    check("cedge_busy_e9", busy, 0);
    step();
    check("cedge_busy_e10", busy, 1);
    repeat (9) step();
    check("cedge_shown_e19", shown, 9);
    check("cedge_busy_e19", busy, 0);

    pulse(8'd200, 1'b0);
    repeat (3) step();
    rst = 1'b1;
    #1;
    check("mrst_seg", seg, 7'h7F);
    check("mrst_dig", dig, 4'hF);
    check("mrst_busy", busy, 0);
    check("mrst_shown", shown, 0);
    step();
    rst = 1'b0;
    repeat (12) step();
    check("post_shown", shown, 0);
    check("post_busy", busy, 0);
    wait_dig(4'b1110, 7'h7F, "post_d0");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
